// File: rtl/pwm_multi_core.sv
// N-channel PWM with a shared prescaler and period counter, edge/center modes, double-buffered config.
// Define PWM_POLARITY_EN to add the staged per-channel polarity input i_pol.
module pwm_multi_core #(
  parameter int R   = 10,
  parameter int N   = 4,
  parameter int PSW = 32
) (
  input  logic               i_clk,
  input  logic               i_nrst,
  input  logic               i_en,
  input  logic [PSW-1:0]     i_scaler,
  input  logic [R-1:0]       i_top,
  input  logic               i_mode,
  input  logic [N*(R+1)-1:0] i_duty,
`ifdef PWM_POLARITY_EN
  input  logic [N-1:0]       i_pol,
`endif
  input  logic               i_load,
  output logic [N-1:0]       o_pwm,
  output logic               o_period_end,
  output logic               o_load_ack
);

  typedef enum logic {DIR_UP, DIR_DOWN} dir_t;

  typedef struct packed {
    logic [R-1:0]       top;
    logic               mode;
    logic [N*(R+1)-1:0] duty;
    logic [N-1:0]       pol;
  } cfg_t;

  localparam cfg_t CFG_RST = '{top: {R{1'b1}}, mode: 1'b0, duty: '0, pol: '0};

  logic [N-1:0] pol_in;
`ifdef PWM_POLARITY_EN
  assign pol_in = i_pol;
`else
  assign pol_in = '0;
`endif

  cfg_t           cfg_in, cfg_s, cfg_a;
  logic           pending;
  logic [PSW-1:0] psc;
  logic [R-1:0]   cnt, cnt_nxt;
  dir_t           dir, dir_nxt;
  logic           tick, center, bnd, xfer;
  logic           bnd_q, xfer_q;
  logic [N-1:0]   pwm_nxt;

  assign cfg_in = '{top: i_top, mode: i_mode, duty: i_duty, pol: pol_in};

  // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
  always_comb begin
    cnt_nxt = cnt;
    dir_nxt = dir;
    bnd     = 1'b0;
    tick    = i_en && (psc >= i_scaler);
    // A zero top in center mode degenerates to the edge-mode sequence.
    center  = cfg_a.mode && (cfg_a.top != '0);
    if (tick) begin
      if (!center) begin
        if (cnt == cfg_a.top) begin
          cnt_nxt = '0;
          bnd     = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end else if (dir == DIR_UP) begin
        cnt_nxt = cnt + 1'b1;
        if (cnt_nxt == cfg_a.top) dir_nxt = DIR_DOWN;
      end else begin
        cnt_nxt = cnt - 1'b1;
        if (cnt_nxt == '0) begin
          dir_nxt = DIR_UP;
          bnd     = 1'b1;
        end
      end
    end
    // While disabled every cycle counts as a boundary for handing staged values over.
    xfer = (pending || i_load) && (bnd || !i_en);
    for (int k = 0; k < N; k++) begin
      pwm_nxt[k] = i_en ? (({1'b0, cnt} < cfg_a.duty[k*(R+1) +: R+1]) ^ cfg_a.pol[k])
                        : cfg_a.pol[k];
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      psc          <= '0;
      cnt          <= '0;
      dir          <= DIR_UP;
      cfg_a        <= CFG_RST;
      cfg_s        <= CFG_RST;
      pending      <= 1'b0;
      bnd_q        <= 1'b0;
      xfer_q       <= 1'b0;
      o_pwm        <= '0;
      o_period_end <= 1'b0;
      o_load_ack   <= 1'b0;
    end else begin
      psc <= (!i_en || tick) ? '0 : psc + 1'b1;
      if (!i_en) begin
        cnt <= '0;
        dir <= DIR_UP;
      end else begin
        cnt <= cnt_nxt;
        dir <= dir_nxt;
      end
      if (xfer) begin
        cfg_a   <= i_load ? cfg_in : cfg_s;
        pending <= 1'b0;
        cnt     <= '0;
        dir     <= DIR_UP;
      end else if (i_load) begin
        cfg_s   <= cfg_in;
        pending <= 1'b1;
      end
      // Events ride one extra stage so they line up with the registered compare of cnt==0.
      bnd_q        <= bnd;
      xfer_q       <= xfer;
      o_period_end <= bnd_q;
      o_load_ack   <= xfer_q;
      o_pwm        <= pwm_nxt;
    end
  end

endmodule

// File: tb/tb_pwm_multi_core.sv
// Self-checking bench for pwm_multi_core: directed scenarios plus randomized traffic against
// a phase-index reference model.
module tb_pwm_multi_core;
  localparam int R   = 4;
  localparam int N   = 4;
  localparam int PSW = 8;
  localparam int DW  = R + 1;

  logic               i_clk = 1'b0;
  logic               i_nrst = 1'b0;
  logic               i_en = 1'b0;
  logic [PSW-1:0]     i_scaler = '0;
  logic [R-1:0]       i_top = '0;
  logic               i_mode = 1'b0;
  logic [N*DW-1:0]    i_duty = '0;
  logic               i_load = 1'b0;
  logic [N-1:0]       o_pwm;
  logic               o_period_end, o_load_ack;
  logic [N-1:0]       pol_in;
`ifdef PWM_POLARITY_EN
  logic [N-1:0]       i_pol = '0;
  assign pol_in = i_pol;
`else
  assign pol_in = '0;
`endif

  pwm_multi_core #(.R(R), .N(N), .PSW(PSW)) dut (
    .i_clk(i_clk), .i_nrst(i_nrst), .i_en(i_en), .i_scaler(i_scaler),
    .i_top(i_top), .i_mode(i_mode), .i_duty(i_duty),
`ifdef PWM_POLARITY_EN
    .i_pol(i_pol),
`endif
    .i_load(i_load), .o_pwm(o_pwm), .o_period_end(o_period_end), .o_load_ack(o_load_ack)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Reference model: position within the period as a plain tick index, cnt derived from it.
  int          m_psc, m_ph, m_top, m_mode, s_top, s_mode;
  int          m_duty[N];
  int          s_duty[N];
  logic [N-1:0] m_pol, s_pol;
  bit          m_pend, b_d1, x_d1, e_pe, e_ack;
  logic [N-1:0] e_pwm;

  function automatic int period_len();
    return (m_mode != 0 && m_top > 0) ? 2 * m_top : m_top + 1;
  endfunction

  function automatic int cnt_of(input int ph);
    return (m_mode != 0 && m_top > 0 && ph > m_top) ? 2 * m_top - ph : ph;
  endfunction

  task automatic model_reset();
    m_psc = 0; m_ph = 0; m_top = 2**R - 1; m_mode = 0; m_pol = '0;
    s_top = 2**R - 1; s_mode = 0; s_pol = '0; m_pend = 0;
    for (int k = 0; k < N; k++) begin m_duty[k] = 0; s_duty[k] = 0; end
    b_d1 = 0; x_d1 = 0; e_pe = 0; e_ack = 0; e_pwm = '0;
  endtask

  task automatic model_step();
    int c;
    bit tick, b, x;
    logic [N-1:0] pw;
    c = cnt_of(m_ph);
    for (int k = 0; k < N; k++) pw[k] = i_en ? ((c < m_duty[k]) ^ m_pol[k]) : m_pol[k];
    tick = i_en && (m_psc >= int'(i_scaler));
    b = tick && (m_ph == period_len() - 1);
    x = (m_pend || i_load) && (b || !i_en);
    m_psc = (!i_en || tick) ? 0 : m_psc + 1;
    if (!i_en) m_ph = 0;
    else if (tick) m_ph = b ? 0 : m_ph + 1;
    if (x) begin
      if (i_load) begin
        m_top = int'(i_top); m_mode = int'(i_mode); m_pol = pol_in;
        for (int k = 0; k < N; k++) m_duty[k] = int'(i_duty[k*DW +: DW]);
      end else begin
        m_top = s_top; m_mode = s_mode; m_pol = s_pol;
        for (int k = 0; k < N; k++) m_duty[k] = s_duty[k];
      end
      m_pend = 0; m_ph = 0;
    end else if (i_load) begin
      s_top = int'(i_top); s_mode = int'(i_mode); s_pol = pol_in;
      for (int k = 0; k < N; k++) s_duty[k] = int'(i_duty[k*DW +: DW]);
      m_pend = 1;
    end
    e_pwm = pw; e_pe = b_d1; e_ack = x_d1; b_d1 = b; x_d1 = x;
  endtask

  // One clock: advance the model with the inputs the DUT sampled, then compare just after the edge.
  task automatic cycle();
    @(posedge i_clk);
    if (!i_nrst) model_reset();
    else model_step();
    #1;
    check("pwm", 32'(o_pwm), 32'(e_pwm));
    check("period_end", 32'(o_period_end), 32'(e_pe));
    check("load_ack", 32'(o_load_ack), 32'(e_ack));
  endtask

  task automatic load_cfg(input int top, input int mode, input int d0, input int d1,
                          input int d2, input int d3);
    i_top = R'(top); i_mode = 1'(mode);
    i_duty = {DW'(d3), DW'(d2), DW'(d1), DW'(d0)};
    i_load = 1'b1;
    cycle();
    i_load = 1'b0;
  endtask

  task automatic wait_ack(input int budget);
    int n;
    n = 0;
    while (!o_load_ack && n < budget) begin cycle(); n++; end
    check("ack_seen", 32'(o_load_ack), 1);
    check("ack_with_pe", 32'(o_period_end), 1);
  endtask

  task automatic wait_pe(input int budget);
    int n;
    n = 0;
    while (!o_period_end && n < budget) begin cycle(); n++; end
    check("pe_seen", 32'(o_period_end), 1);
  endtask

  int hcount[N];
  int ends, acks;

  task automatic measure(input int ncyc);
    for (int k = 0; k < N; k++) hcount[k] = 0;
    ends = 0; acks = 0;
    for (int i = 0; i < ncyc; i++) begin
      for (int k = 0; k < N; k++) hcount[k] += int'(o_pwm[k]);
      ends += int'(o_period_end);
      acks += int'(o_load_ack);
      cycle();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    model_reset();
    repeat (2) cycle();
    check("rst_pwm", 32'(o_pwm), 0);
    check("rst_pe", 32'(o_period_end), 0);
    check("rst_ack", 32'(o_load_ack), 0);
    #2 i_nrst = 1'b1;
    i_en = 1'b1;
    repeat (40) cycle();

    // Edge mode, top 9, duty 3/0/10/31.
    load_cfg(9, 0, 3, 0, 10, 31);
    wait_ack(60);
    measure(30);
    check("edge_ch0_high", hcount[0], 9);
    check("edge_ch1_zero", hcount[1], 0);
    check("edge_ch2_full", hcount[2], 30);
    check("edge_ch3_full", hcount[3], 30);
    check("edge_ends", ends, 3);

    // Prescaler 2: each count lasts three clocks.
    i_scaler = 8'd2;
    cycle();
    wait_pe(100);
    measure(90);
    check("psc_ch0_high", hcount[0], 27);
    check("psc_ends", ends, 3);

    // Prescaler shrinks below the running count.
    i_scaler = 8'd5;
    repeat (4) cycle();
    i_scaler = 8'd1;
    repeat (30) cycle();
    i_scaler = 8'd0;

    // Center mode, top 4.
    load_cfg(4, 1, 2, 0, 5, 1);
    wait_ack(100);
    measure(16);
    check("ctr_ch0_high", hcount[0], 6);
    check("ctr_ch1_zero", hcount[1], 0);
    check("ctr_ch2_full", hcount[2], 16);
    check("ctr_ch3_high", hcount[3], 2);
    check("ctr_ends", ends, 2);

    // Mid-period load, duty 3 -> 7.
    load_cfg(9, 0, 3, 0, 10, 31);
    wait_ack(60);
    repeat (3) cycle();
    load_cfg(9, 0, 7, 0, 10, 31);
    wait_ack(30);
    measure(10);
    check("mid_ch0_high", hcount[0], 7);
    check("mid_ends", ends, 1);
    check("pe_again", 32'(o_period_end), 1);

    // Load coincident with the boundary applies in that same period change.
    repeat (8) cycle();
    load_cfg(9, 0, 5, 0, 10, 31);
    cycle();
    check("coinc_ack", 32'(o_load_ack), 1);
    check("coinc_pe", 32'(o_period_end), 1);
    measure(10);
    check("coinc_ch0_high", hcount[0], 5);

    // Disabled: outputs inactive, load transfers at once.
    i_en = 1'b0;
    repeat (3) cycle();
    check("en0_pwm", 32'(o_pwm), 0);
    load_cfg(9, 0, 2, 4, 6, 8);
    cycle();
    check("en0_ack", 32'(o_load_ack), 1);
    i_en = 1'b1;
    repeat (25) cycle();

    // Randomized traffic.
    for (int it = 0; it < 3000; it++) begin
      if (!i_en && $urandom_range(0, 3) == 0) i_en = 1'b1;
      else if (i_en && $urandom_range(0, 59) == 0) i_en = 1'b0;
      if ($urandom_range(0, 99) == 0) i_scaler = PSW'($urandom_range(0, 3));
      i_load = ($urandom_range(0, 11) == 0);
      if (i_load) begin
        i_top = R'($urandom_range(0, 15));
        i_mode = 1'($urandom_range(0, 1));
        for (int k = 0; k < N; k++) i_duty[k*DW +: DW] = DW'($urandom_range(0, 31));
`ifdef PWM_POLARITY_EN
        i_pol = N'($urandom_range(0, 15));
`endif
      end
      cycle();
    end
    i_load = 1'b0;
    i_en = 1'b1;
    i_scaler = 8'd0;
`ifdef PWM_POLARITY_EN
    i_pol = '0;
`endif

    // Async reset mid-period with a load pending.
    load_cfg(15, 0, 9, 9, 9, 9);
    wait_ack(200);
    repeat (2) cycle();
    load_cfg(3, 1, 1, 1, 1, 1);
    cycle();
    #3 i_nrst = 1'b0;
    #1;
    check("arst_pwm", 32'(o_pwm), 0);
    check("arst_pe", 32'(o_period_end), 0);
    check("arst_ack", 32'(o_load_ack), 0);
    repeat (2) cycle();
    #2 i_nrst = 1'b1;
    measure(40);
    check("post_rst_ch0", hcount[0], 0);
    check("post_rst_ch3", hcount[3], 0);
    check("post_rst_acks", acks, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_multi_core.md
Name: pwm_multi_core

Overview:
N-channel PWM generator with a shared programmable prescaler and a shared period counter. Each channel has its own duty compare. Edge-aligned and center-aligned modes are supported. Duty, period and mode are double-buffered: new values are staged on request and take effect only at a period boundary, so no glitch or partial period appears. This block succeeds the single-channel fixed-period PWM core and feeds motor/LED driver pads.

Parameters:
R, 10, counter/period resolution in bits; duty inputs are R+1 bits so 100% duty is expressible
N, 4, number of PWM channels
PSW, 32, prescaler width in bits

Ports:
i_clk  input  1  clock
i_nrst  input  1  reset, asynchronous, active-low
i_en  input  1  run enable; low holds counters at start and forces outputs inactive
i_scaler  input  PSW  prescale value; counter advances every i_scaler+1 clocks
i_top  input  R  period top value (staged)
i_mode  input  1  0 = edge-aligned, 1 = center-aligned (staged)
i_duty  input  N*(R+1)  per-channel duty, channel k at bits [k*(R+1) +: R+1] (staged)
i_load  input  1  one-cycle strobe; captures i_top/i_mode/i_duty into the staging registers
o_pwm  output  N  PWM outputs, registered
o_period_end  output  1  one-cycle pulse, first cycle of each new period
o_load_ack  output  1  one-cycle pulse when staged values become active

Behaviour:
- Reset: prescaler=0, cnt=0, dir=up, active duty=0 for all channels, active top=2^R-1, active mode=edge, pending=0. o_pwm, o_period_end and o_load_ack all 0.
- Prescaler: psc counts 0..i_scaler. tick=1 when psc>=i_scaler, then psc<=0; otherwise psc+1. i_scaler=0 gives a tick every clock. A change to i_scaler applies immediately; if psc exceeds the new value it wraps on the next clock.
- Edge mode, on each tick: if cnt==top_a, cnt<=0 and boundary B=1; else cnt+1. Period = (top_a+1)*(i_scaler+1) clocks.
- Center mode (top_a>=1), on each tick:
  - dir up: cnt+1, and dir<=down when cnt+1==top_a.
  - dir down: cnt-1, and when cnt-1==0, dir<=up and B=1.
  - Sequence is 0,1..top,top-1..1,0. Period = 2*top_a ticks.
- Center mode with top_a==0: behaves as edge mode (cnt stays 0, B on every tick).
- Staging: i_load writes the staging registers and sets pending. A repeated i_load while pending overwrites the staged values.
- Transfer at B when pending: active <= staged, pending<=0, cnt<=0, dir<=up.
  - i_load coincident with B: the new inputs go straight to active in that cycle.
- Channel compare: pwm_next[k] = (cnt < duty_a[k]) in both modes; output registered (1-clock latency from cnt).
  - duty_a=0: constant low.
  - duty_a>=top_a+1: constant high for the full period, no glitch.
- o_period_end and o_load_ack are registered versions of B and of the transfer, so both coincide with the first o_pwm cycle of the new period.
- i_en=0:
  - psc=0, cnt=0, dir=up, o_pwm=0, no B.
  - i_load transfers staged values to active on the next clock, and o_load_ack pulses.
  - On i_en rising, the counter starts from 0 with the current active set.
- Async reset mid-period clears everything to reset values, including pending.

Optional Feature:
PWM_POLARITY_EN
- Defined: adds port i_pol (input, N bits, staged with i_duty). Channel k output is inverted when the active pol[k]=1. With i_en=0, the output sits at the inactive level, i.e. pol[k].
- Undefined: no i_pol port; outputs are active-high only.

Test Plan:
- R=4, i_scaler=0, edge, top=9, duty ch0=3: o_pwm[0] high 3 clocks / low 7 clocks repeating; o_period_end every 10 clocks.
- i_scaler=2, same setup: high 9 / low 21 clocks; psc wraps correctly after i_scaler changes 5->1 mid-count.
- Center mode, top=4, duty=2: cnt sequence 0,1,2,3,4,3,2,1; o_pwm high for cnt 0,1 and again at cnt 1 (symmetric); period 8 ticks.
- Duty 0 -> constant low; duty=top+1=10 -> constant high with no single-cycle low at wrap; duty 31 (R=4) -> constant high.
- i_load mid-period with duty 3->7: old duty holds until B; o_load_ack and the new duty appear together in the first cycle of the next period. i_load coincident with B applies immediately.
- Assert i_nrst low mid-period with pending load: all outputs 0 and pending dropped; after release, top=15, edge, duty 0.
